// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory loader: FSM encoding and packing width.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERR
    } ldr_state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream MSB-first into 32-bit words and keeps a running XOR of every byte.
// word_valid pulses for one cycle after the last byte of a word; word holds that word then.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_last,
    output logic        word_valid,
    output logic [7:0]  xor_acc
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0] idx;

    assign word_last = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            word       <= '0;
            idx        <= '0;
            word_valid <= 1'b0;
            xor_acc    <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                word    <= '0;
                idx     <= '0;
                xor_acc <= '0;
            end else if (shift_en) begin
                word       <= {word[23:0], byte_in};
                xor_acc    <= xor_acc ^ byte_in;
                idx        <= idx + 2'd1;
                word_valid <= word_last;
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory and
// releases the core's reset only after a clean image has been written.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [CNT_W-1:0] words_done,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             core_rst,
    output logic [2:0]       state_dbg
);

    // Valid/ready: a byte moves on a rising edge where byte_valid && byte_ready;
    // byte_ready is a pure function of state and never looks at byte_valid.

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_WORDS);

    ldr_state_t       state;
    ldr_state_t       state_next;
    logic [7:0]       len_hi_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] n_next;
    logic [CNT_W-1:0] words_rcvd;
    logic [31:0]      mem_addr_q;
    logic             xfer;
    logic             launch;
    logic             shift_en;
    logic             word_last;
    logic             word_valid;
    logic [31:0]      packed_word;
    logic [7:0]       xor_acc;
    logic             last_word;

    assign xfer      = byte_valid & byte_ready;
    assign launch    = start & ~busy;
    assign shift_en  = xfer & (state == DATA);
    assign n_next    = CNT_W'({len_hi_q, byte_in});
    assign last_word = (words_rcvd == n_q - CNT_W'(1));

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (launch),
        .shift_en   (shift_en),
        .byte_in    (byte_in),
        .word       (packed_word),
        .word_last  (word_last),
        .word_valid (word_valid),
        .xor_acc    (xor_acc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) state_next = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) state_next = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) begin
                    if (n_next > DEPTH_CNT)  state_next = ERR;
                    else if (n_next == '0)   state_next = CHECK;
                    else                     state_next = DATA;
                end
            end
            DATA: begin
                if (xfer && word_last && last_word) state_next = CHECK;
            end
            CHECK: begin
                if (xfer) state_next = (byte_in == xor_acc) ? DONE : ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        core_rst   = 1'b0;
        unique case (state)
            LEN_HI, LEN_LO, DATA, CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            DONE: begin
                done     = 1'b1;
                core_rst = 1'b1;
            end
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

    // The write address is captured when a word completes, so it stays put after the pulse
    // even though words_done moves on.
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_hi_q   <= '0;
            n_q        <= '0;
            words_rcvd <= '0;
            words_done <= '0;
            mem_addr_q <= '0;
        end else begin
            if (launch) begin
                words_rcvd <= '0;
                words_done <= '0;
            end else begin
                if (xfer && state == LEN_HI) len_hi_q <= byte_in;
                if (xfer && state == LEN_LO) n_q <= n_next;
                if (shift_en && word_last) begin
                    words_rcvd <= words_rcvd + CNT_W'(1);
                    mem_addr_q <= 32'({words_rcvd, 2'b00});
                end
                if (word_valid) words_done <= words_done + CNT_W'(1);
            end
        end
    end

    assign mem_we    = word_valid;
    assign mem_wdata = packed_word;
    assign mem_addr  = mem_addr_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader: a byte-level image model predicts
// every memory write and the final done/err/core_rst outcome of each load.
module tb_instr_mem_loader;

    localparam int DEPTH = 256;
    localparam int CW    = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [CW-1:0] words_done;
    logic          busy;
    logic          done;
    logic          err;
    logic          core_rst;
    logic [2:0]    state_dbg;

    int            checks;
    int            errors;
    int            wr_count;
    logic [63:0]   exp_q[$];
    logic [7:0]    data_q[$];

    instr_mem_loader #(.DEPTH_WORDS(DEPTH), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .words_done (words_done),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .core_rst   (core_rst),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: every write strobe must match the next expected {addr, data}
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst && mem_we) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_we", {mem_addr, mem_wdata}, 64'hDEAD_0000_DEAD_0000);
            end else begin
                e = exp_q.pop_front();
                check("mem_write", {mem_addr, mem_wdata}, e);
            end
        end
    end

    // driver: called and returns on a falling edge
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int t;
        int g;
        g = 0;
        while (g < 6 && int'($urandom_range(99)) < gap_pct) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            @(negedge clk);
            g++;
        end
        byte_valid = 1'b1;
        byte_in    = b;
        t = 0;
        while (!byte_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) check("ready_timeout", 64'(byte_ready), 64'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One full load using data_q as payload; the model derives writes and checksum from bytes.
    task automatic run_load(input int n, input bit corrupt, input int gap_pct, input int mid_start);
        logic [15:0] nn;
        logic [7:0]  chk;
        logic [31:0] w;
        bit          fits;
        bit          exp_ok;
        int          wr0;
        int          t;
        nn   = 16'(n);
        fits = (n <= DEPTH);
        chk  = 8'h00;
        if (fits) begin
            for (int i = 0; i < n; i++) begin
                w = {data_q[4*i], data_q[4*i+1], data_q[4*i+2], data_q[4*i+3]};
                exp_q.push_back({32'(4 * i), w});
                chk = chk ^ data_q[4*i] ^ data_q[4*i+1] ^ data_q[4*i+2] ^ data_q[4*i+3];
            end
        end
        if (corrupt) chk = chk ^ 8'h01;
        wr0 = wr_count;
        pulse_start();
        check("after_start {busy,done,err,core_rst}", 64'({busy, done, err, core_rst}), 64'b1000);
        send_byte(nn[15:8], gap_pct);
        send_byte(nn[7:0], gap_pct);
        if (!fits) begin
            check("overflow {err,byte_ready,busy}", 64'({err, byte_ready, busy}), 64'b100);
        end else begin
            for (int i = 0; i < 4 * n; i++) begin
                send_byte(data_q[i], gap_pct);
                if (i == mid_start) begin
                    pulse_start();
                    check("mid_start_ignored busy", 64'(busy), 64'd1);
                end
            end
            send_byte(chk, gap_pct);
        end
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        exp_ok = fits && !corrupt;
        check("final {done,err,core_rst,busy}", 64'({done, err, core_rst, busy}),
              64'({exp_ok, !exp_ok, exp_ok, 1'b0}));
        check("words_done", 64'(words_done), fits ? 64'(n) : 64'd0);
        check("write_count", 64'(wr_count - wr0), fits ? 64'(n) : 64'd0);
        check("writes_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic fill_random(input int n);
        data_q.delete();
        for (int i = 0; i < 4 * n; i++) data_q.push_back(8'($urandom));
    endtask

    task automatic fill_example();
        data_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h00};
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        wr_count   = 0;
        rst        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        repeat (2) @(negedge clk);
        check("reset {byte_ready,mem_we,core_rst,done,err,busy}",
              64'({byte_ready, mem_we, core_rst, done, err, busy}), 64'd0);
        check("reset words_done", 64'(words_done), 64'd0);
        check("reset mem_addr", 64'(mem_addr), 64'd0);
        byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("idle byte_ready", 64'(byte_ready), 64'd0);

        // example image, good checksum then a checksum one bit off
        fill_example();
        run_load(2, 1'b0, 0, -1);
        fill_example();
        run_load(2, 1'b1, 0, -1);

        // length one past capacity, then empty image
        data_q.delete();
        run_load(DEPTH + 1, 1'b0, 0, -1);
        run_load(0, 1'b0, 0, -1);

        // example image with random valid gaps
        fill_example();
        run_load(2, 1'b0, 40, -1);

        // abort mid-data with reset, then reload cleanly
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort {busy,done,err,core_rst,mem_we}", 64'({busy, done, err, core_rst, mem_we}), 64'd0);
        check("abort words_done", 64'(words_done), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        fill_example();
        run_load(2, 1'b0, 0, -1);

        // start while busy in DATA is ignored
        fill_example();
        run_load(2, 1'b0, 0, 4);

        // full capacity image
        fill_random(DEPTH);
        run_load(DEPTH, 1'b0, 0, -1);

        // random images
        for (int k = 0; k < 8; k++) begin
            int n;
            n = int'($urandom_range(1, 6));
            fill_random(n);
            run_load(n, ($urandom_range(3) == 0), int'($urandom_range(0, 50)),
                     ($urandom_range(1) == 0) ? int'($urandom_range(0, 4 * n - 2)) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
